// File: rtl/dcache_victim_buffer.sv
// -----------------------------------------------------------------------------
// dcache_victim_buffer
//
// Fully-associative victim buffer between the write-back data cache and
// memory. Holds clean and dirty lines evicted from the cache. A later miss
// that hits the buffer hands the line back to the cache.
//
// Features:
//   - Dirty tracking per entry.
//   - Round-robin replacement once the buffer is full.
//   - Writeback of a dirty victim on overflow.
//   - Walking flush that writes back every dirty line.
//
// Optional feature macro: VICTIM_PERF_CNT_EN
//   Defined   : hit_cnt_o / miss_cnt_o are saturating 32-bit lookup counters.
//   Undefined : no counter logic; both ports are tied to 0.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   lookup_req_i/lookup_addr_i  associative lookup request
//   lookup_hit_o/_data_o/_dirty_o
//                               registered lookup result (1-cycle latency)
//   take_i                      invalidate the entry reported by lookup_hit_o
//   ins_valid_i/ins_ready_o     insert handshake for an evicted cache line
//   ins_addr_i/_data_i/_dirty_i inserted line
//   wb_valid_o/wb_ready_i       writeback handshake towards memory
//   wb_addr_o/wb_data_o         writeback line
//   flush_i                     flush request pulse
//   flush_done_o                one-cycle pulse at the end of a flush
//   hit_cnt_o/miss_cnt_o        lookup statistics
// -----------------------------------------------------------------------------
module dcache_victim_buffer #(
  parameter int NUM_ENTRIES = 4,
  parameter int LINE_WIDTH  = 128,
  parameter int TAG_WIDTH   = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_req_i,
  input  logic [TAG_WIDTH-1:0]  lookup_addr_i,
  output logic                  lookup_hit_o,
  output logic [LINE_WIDTH-1:0] lookup_data_o,
  output logic                  lookup_dirty_o,
  input  logic                  take_i,
  input  logic                  ins_valid_i,
  output logic                  ins_ready_o,
  input  logic [TAG_WIDTH-1:0]  ins_addr_i,
  input  logic [LINE_WIDTH-1:0] ins_data_i,
  input  logic                  ins_dirty_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [TAG_WIDTH-1:0]  wb_addr_o,
  output logic [LINE_WIDTH-1:0] wb_data_o,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, WB_EVICT, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [TAG_WIDTH-1:0]    tag_mem  [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0]   data_mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  valid_reg, valid_next, dirty_reg, dirty_next;
  logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next, idx_reg, idx_next;
  logic                    flush_pending_reg, flush_pending_next;
  logic [TAG_WIDTH-1:0]    wb_addr_reg;
  logic [LINE_WIDTH-1:0]   wb_data_reg;
  logic                    lookup_hit_reg, lookup_dirty_reg;
  logic [LINE_WIDTH-1:0]   lookup_data_reg;
  logic [IDX_W-1:0]        lookup_idx_reg;

  logic [NUM_ENTRIES-1:0]  lookup_match, ins_match, take_mask, live;
  logic [IDX_W-1:0]        lookup_idx, ins_match_idx, free_idx, wr_idx, wb_src_idx;
  logic                    lookup_any, ins_match_any, free_any, wr_en, wb_load;

  // take_i only acts on a reported hit; the remaining "live" set is what an
  // insert in the same cycle sees, so a slot freed by take_i is reusable.
  assign take_mask = (take_i && lookup_hit_reg) ? (NUM_ENTRIES'(1) << lookup_idx_reg) : '0;
  assign live      = valid_reg & ~take_mask;

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
      assign lookup_match[gi] = valid_reg[gi] && (tag_mem[gi] == lookup_addr_i);
      assign ins_match[gi]    = live[gi] && (tag_mem[gi] == ins_addr_i);
    end
  endgenerate

  assign lookup_any    = |lookup_match;
  assign ins_match_any = |ins_match;
  assign free_any      = ~&live;

  // Priority encoders: walking downwards leaves the lowest index selected.
  always_comb begin
    lookup_idx    = '0;
    ins_match_idx = '0;
    free_idx      = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (lookup_match[i]) lookup_idx    = IDX_W'(i);
      if (ins_match[i])    ins_match_idx = IDX_W'(i);
      if (!live[i])        free_idx      = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next         = state_reg;
    valid_next         = live;
    dirty_next         = dirty_reg & ~take_mask;
    rr_ptr_next        = rr_ptr_reg;
    idx_next           = idx_reg;
    flush_pending_next = flush_pending_reg | flush_i;
    wr_en              = 1'b0;
    wr_idx             = '0;
    wb_load            = 1'b0;
    wb_src_idx         = '0;
    ins_ready_o        = 1'b0;
    wb_valid_o         = 1'b0;
    flush_done_o       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        ins_ready_o = !(flush_i || flush_pending_reg);
        if (flush_i || flush_pending_reg) begin
          state_next         = FLUSH_SCAN;
          idx_next           = '0;
          flush_pending_next = 1'b0;
        end else if (ins_valid_i) begin
          wr_en = 1'b1;
          if (ins_match_any) begin
            wr_idx             = ins_match_idx;
            dirty_next[wr_idx] = dirty_reg[wr_idx] | ins_dirty_i;
          end else if (free_any) begin
            wr_idx             = free_idx;
            dirty_next[wr_idx] = ins_dirty_i;
          end else begin
            wr_idx      = rr_ptr_reg;
            rr_ptr_next = rr_ptr_reg + IDX_W'(1);
            if (dirty_reg[rr_ptr_reg]) begin
              wb_load    = 1'b1;
              wb_src_idx = rr_ptr_reg;
              state_next = WB_EVICT;
            end
            dirty_next[wr_idx] = ins_dirty_i;
          end
          valid_next[wr_idx] = 1'b1;
        end
      end
      WB_EVICT: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) state_next = IDLE;
      end
      FLUSH_SCAN: begin
        if (live[idx_reg] && dirty_reg[idx_reg]) begin
          wb_load    = 1'b1;
          wb_src_idx = idx_reg;
          state_next = FLUSH_WB;
        end else begin
          valid_next[idx_reg] = 1'b0;
          dirty_next[idx_reg] = 1'b0;
          idx_next            = idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) state_next = FLUSH_DONE;
        end
      end
      FLUSH_WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) begin
          valid_next[idx_reg] = 1'b0;
          dirty_next[idx_reg] = 1'b0;
          idx_next            = idx_reg + IDX_W'(1);
          // The last index has nothing left to scan, so finish directly.
          state_next          = (idx_reg == LAST_IDX) ? FLUSH_DONE : FLUSH_SCAN;
        end
      end
      FLUSH_DONE: begin
        flush_done_o = 1'b1;
        rr_ptr_next  = '0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg         <= '0;
      dirty_reg         <= '0;
      rr_ptr_reg        <= '0;
      idx_reg           <= '0;
      flush_pending_reg <= 1'b0;
      wb_addr_reg       <= '0;
      wb_data_reg       <= '0;
      lookup_hit_reg    <= 1'b0;
      lookup_dirty_reg  <= 1'b0;
      lookup_data_reg   <= '0;
      lookup_idx_reg    <= '0;
    end else begin
      valid_reg         <= valid_next;
      dirty_reg         <= dirty_next;
      rr_ptr_reg        <= rr_ptr_next;
      idx_reg           <= idx_next;
      flush_pending_reg <= flush_pending_next;
      if (wb_load) begin
        wb_addr_reg <= tag_mem[wb_src_idx];
        wb_data_reg <= data_mem[wb_src_idx];
      end
      // Lookup reads pre-insert contents: the arrays update on this same edge.
      lookup_hit_reg <= lookup_req_i && lookup_any;
      lookup_idx_reg <= lookup_idx;
      if (lookup_req_i && lookup_any) begin
        lookup_data_reg  <= data_mem[lookup_idx];
        lookup_dirty_reg <= dirty_reg[lookup_idx];
      end else begin
        lookup_data_reg  <= '0;
        lookup_dirty_reg <= 1'b0;
      end
    end
  end

  // Line storage carries no reset; the valid bits qualify its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= ins_addr_i;
      data_mem[wr_idx] <= ins_data_i;
    end
  end

  assign lookup_hit_o   = lookup_hit_reg;
  assign lookup_data_o  = lookup_data_reg;
  assign lookup_dirty_o = lookup_dirty_reg;
  assign wb_addr_o      = wb_addr_reg;
  assign wb_data_o      = wb_data_reg;

`ifdef VICTIM_PERF_CNT_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (lookup_req_i) begin
      if (lookup_any) begin
        if (hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end else begin
        if (miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_reg;
  assign miss_cnt_o = miss_cnt_reg;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcache_victim_buffer
//
// Directed scenarios followed by a randomized run checked against a
// behavioural model of the buffer (entry table, round-robin pointer,
// pending-writeback flag, lookup counters).
// -----------------------------------------------------------------------------
module tb_dcache_victim_buffer;

  localparam int N  = 4;
  localparam int LW = 128;
  localparam int TW = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lookup_req_i = 1'b0;
  logic [TW-1:0] lookup_addr_i = '0;
  logic          lookup_hit_o;
  logic [LW-1:0] lookup_data_o;
  logic          lookup_dirty_o;
  logic          take_i = 1'b0;
  logic          ins_valid_i = 1'b0;
  logic          ins_ready_o;
  logic [TW-1:0] ins_addr_i = '0;
  logic [LW-1:0] ins_data_i = '0;
  logic          ins_dirty_i = 1'b0;
  logic          wb_valid_o;
  logic          wb_ready_i = 1'b0;
  logic [TW-1:0] wb_addr_o;
  logic [LW-1:0] wb_data_o;
  logic          flush_i = 1'b0;
  logic          flush_done_o;
  logic [31:0]   hit_cnt_o;
  logic [31:0]   miss_cnt_o;

  always #5 clk = ~clk;

  dcache_victim_buffer #(.NUM_ENTRIES(N), .LINE_WIDTH(LW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
    .lookup_hit_o(lookup_hit_o), .lookup_data_o(lookup_data_o), .lookup_dirty_o(lookup_dirty_o),
    .take_i(take_i),
    .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o), .ins_addr_i(ins_addr_i),
    .ins_data_i(ins_data_i), .ins_dirty_i(ins_dirty_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  int errors = 0;
  int checks = 0;
  logic [TW-1:0] wb_seen[$];

  typedef struct packed {
    logic          v;
    logic          d;
    logic [TW-1:0] t;
    logic [LW-1:0] dat;
  } ent_t;

  ent_t          m [N];
  int            rr, mh, mm, n_idx, exp_idx, hslot, fslot;
  logic          busy, pend_look, exp_hit, n_hit, exp_dirty, n_dirty;
  logic [TW-1:0] exp_wa, a0, a1;
  logic [LW-1:0] exp_wd, exp_data, n_data, d1, d2;
  logic [31:0]   exp_hc, exp_mc;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] line_of(input logic [TW-1:0] a);
    return {4{4'hA, a}};
  endfunction

  task automatic do_ins(input logic [TW-1:0] a, input logic [LW-1:0] d, input logic dt);
    chk("ins_ready", ins_ready_o, 1'b1);
    ins_valid_i = 1'b1; ins_addr_i = a; ins_data_i = d; ins_dirty_i = dt;
    tick();
    ins_valid_i = 1'b0;
    $display("insert addr=%0h dirty=%0b", a, dt);
  endtask

  task automatic do_look(input logic [TW-1:0] a, input logic eh, input logic [LW-1:0] ed,
                         input logic edt);
    lookup_req_i = 1'b1; lookup_addr_i = a;
    tick();
    lookup_req_i = 1'b0;
    chk("look_hit", lookup_hit_o, eh);
    if (eh) begin
      chk("look_data", lookup_data_o, ed);
      chk("look_dirty", lookup_dirty_o, edt);
    end
    $display("lookup addr=%0h hit=%0b dirty=%0b", a, lookup_hit_o, lookup_dirty_o);
  endtask

  // Collects writeback addresses until flush_done_o, then steps past the pulse.
  task automatic wait_flush();
    wb_seen.delete();
    wb_ready_i = 1'b1;
    for (int i = 0; i < 60 && !flush_done_o; i++) begin
      if (wb_valid_o) begin
        wb_seen.push_back(wb_addr_o);
        $display("writeback addr=%0h", wb_addr_o);
      end
      tick();
    end
    chk("flush_done", flush_done_o, 1'b1);
    tick();
    chk("flush_done_pulse", flush_done_o, 1'b0);
    wb_ready_i = 1'b0;
  endtask

  task automatic run_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_flush();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    d1 = {32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    d2 = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF};

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_hit", lookup_hit_o, 1'b0);
    chk("rst_dirty", lookup_dirty_o, 1'b0);
    chk("rst_data", lookup_data_o, '0);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_flush_done", flush_done_o, 1'b0);
    chk("rst_hit_cnt", hit_cnt_o, '0);
    chk("rst_miss_cnt", miss_cnt_o, '0);
    chk("rst_ins_ready", ins_ready_o, 1'b1);
    rst_n = 1'b1;
    tick();

    // Insert, hit, take, miss
    do_ins(28'h100, d1, 1'b1);
    do_look(28'h100, 1'b1, d1, 1'b1);
    take_i = 1'b1; tick(); take_i = 1'b0;
    do_look(28'h100, 1'b0, '0, 1'b0);

    // take_i without a reported hit is ignored
    do_ins(28'h110, d2, 1'b0);
    do_look(28'h999, 1'b0, '0, 1'b0);
    take_i = 1'b1; tick(); take_i = 1'b0;
    do_look(28'h110, 1'b1, d2, 1'b0);
    run_flush();
    chk("flush1_wb_count", wb_seen.size(), 0);

    // Flush of an empty buffer: done N+1 cycles after flush_i
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    for (int i = 1; i <= N; i++) begin
      tick();
      chk("empty_flush_lat", flush_done_o, (i == N));
    end
    tick();
    chk("empty_flush_pulse", flush_done_o, 1'b0);

    // Clean overflow: silent replacement, round-robin order 0 then 1
    for (int i = 0; i < N; i++) do_ins(28'h200 + TW'(i), line_of(28'h200 + TW'(i)), 1'b0);
    do_ins(28'h204, line_of(28'h204), 1'b0);
    chk("clean_evict_wb", wb_valid_o, 1'b0);
    do_look(28'h200, 1'b0, '0, 1'b0);
    do_look(28'h204, 1'b1, line_of(28'h204), 1'b0);
    do_ins(28'h205, line_of(28'h205), 1'b0);
    do_look(28'h201, 1'b0, '0, 1'b0);
    do_look(28'h202, 1'b1, line_of(28'h202), 1'b0);
    run_flush();
    chk("clean_flush_wb_count", wb_seen.size(), 0);

    // Dirty overflow with stalled memory, flush latched while busy
    for (int i = 0; i < N; i++) do_ins(28'h300 + TW'(i), line_of(28'h300 + TW'(i)), 1'b1);
    wb_ready_i = 1'b0;
    do_ins(28'h304, line_of(28'h304), 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("evict_wb_valid", wb_valid_o, 1'b1);
      chk("evict_wb_addr", wb_addr_o, 28'h300);
      chk("evict_wb_data", wb_data_o, line_of(28'h300));
      chk("evict_ins_ready", ins_ready_o, 1'b0);
      if (i < 3) begin
        flush_i = (i == 0);
        tick();
        flush_i = 1'b0;
      end
    end
    wb_ready_i = 1'b1;
    tick();
    chk("evict_done_wb_valid", wb_valid_o, 1'b0);
    wait_flush();
    a0 = (wb_seen.size() > 0) ? wb_seen[0] : '1;
    chk("pending_flush_wb_count", wb_seen.size(), 4);
    chk("pending_flush_first", a0, 28'h304);

    // Flush with 2 of 4 dirty: writebacks in index order
    do_ins(28'h400, line_of(28'h400), 1'b1);
    do_ins(28'h401, line_of(28'h401), 1'b0);
    do_ins(28'h402, line_of(28'h402), 1'b1);
    do_ins(28'h403, line_of(28'h403), 1'b0);
    run_flush();
    a0 = (wb_seen.size() > 0) ? wb_seen[0] : '1;
    a1 = (wb_seen.size() > 1) ? wb_seen[1] : '1;
    chk("flush2_wb_count", wb_seen.size(), 2);
    chk("flush2_wb_first", a0, 28'h400);
    chk("flush2_wb_second", a1, 28'h402);
    for (int i = 0; i < N; i++) do_look(28'h400 + TW'(i), 1'b0, '0, 1'b0);

    // Re-insert of a resident address merges the dirty bit
    do_ins(28'h700, d1, 1'b1);
    do_ins(28'h700, d2, 1'b0);
    do_look(28'h700, 1'b1, d2, 1'b1);

    // Reset during FLUSH_WB abandons the writeback
    wb_ready_i = 1'b0;
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    for (int i = 0; i < 20 && !wb_valid_o; i++) tick();
    chk("flush_wb_reached", wb_valid_o, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_wb_valid", wb_valid_o, 1'b0);
    chk("rst_mid_hit_cnt", hit_cnt_o, '0);
    chk("rst_mid_miss_cnt", miss_cnt_o, '0);
    rst_n = 1'b1;
    do_look(28'h700, 1'b0, '0, 1'b0);

    // Counters: 3 hits + 2 misses
    do_ins(28'h600, d1, 1'b0);
    for (int i = 0; i < 3; i++) do_look(28'h600, 1'b1, d1, 1'b0);
    do_look(28'h601, 1'b0, '0, 1'b0);
`ifdef VICTIM_PERF_CNT_EN
    exp_hc = 32'd3; exp_mc = 32'd2;
`else
    exp_hc = 32'd0; exp_mc = 32'd0;
`endif
    chk("hit_cnt", hit_cnt_o, exp_hc);
    chk("miss_cnt", miss_cnt_o, exp_mc);

    // Randomized run against the model
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int e = 0; e < N; e++) m[e] = '0;
    rr = 0; mh = 0; mm = 0; busy = 1'b0; pend_look = 1'b0;
    exp_hit = 1'b0; exp_idx = 0; exp_data = '0; exp_dirty = 1'b0; exp_wa = '0; exp_wd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk("r_ins_ready", ins_ready_o, !busy);
      chk("r_wb_valid", wb_valid_o, busy);
      if (busy) begin
        chk("r_wb_addr", wb_addr_o, exp_wa);
        chk("r_wb_data", wb_data_o, exp_wd);
      end
      chk("r_hit", lookup_hit_o, pend_look && exp_hit);
      if (pend_look && exp_hit) begin
        chk("r_data", lookup_data_o, exp_data);
        chk("r_dirty", lookup_dirty_o, exp_dirty);
      end

      take_i        = ($urandom_range(0, 2) == 0);
      lookup_req_i  = !take_i && ($urandom_range(0, 1) == 1);
      lookup_addr_i = 28'h800 + TW'($urandom_range(0, 7));
      ins_valid_i   = ($urandom_range(0, 1) == 1);
      ins_addr_i    = 28'h800 + TW'($urandom_range(0, 7));
      ins_data_i    = {$urandom(), $urandom(), $urandom(), $urandom()};
      ins_dirty_i   = ($urandom_range(0, 1) == 1);
      wb_ready_i    = ($urandom_range(0, 1) == 1);
      $display("rnd %0d look=%0b la=%0h take=%0b ins=%0b ia=%0h dirty=%0b", cyc,
               lookup_req_i, lookup_addr_i, take_i, ins_valid_i, ins_addr_i, ins_dirty_i);

      // Lookup result is taken from the contents before this cycle's updates.
      n_hit = 1'b0; n_idx = 0; n_data = '0; n_dirty = 1'b0;
      for (int e = 0; e < N; e++)
        if (m[e].v && m[e].t == lookup_addr_i) begin
          n_hit = 1'b1; n_idx = e; n_data = m[e].dat; n_dirty = m[e].d;
        end
      if (lookup_req_i) begin
        if (n_hit) mh++;
        else mm++;
      end
      if (take_i && pend_look && exp_hit) begin
        m[exp_idx].v = 1'b0;
        m[exp_idx].d = 1'b0;
      end
      if (busy) begin
        if (wb_ready_i) busy = 1'b0;
      end else if (ins_valid_i) begin
        hslot = -1;
        fslot = -1;
        for (int e = 0; e < N; e++) if (m[e].v && m[e].t == ins_addr_i) hslot = e;
        for (int e = N - 1; e >= 0; e--) if (!m[e].v) fslot = e;
        if (hslot >= 0) begin
          m[hslot].d   = m[hslot].d | ins_dirty_i;
          m[hslot].dat = ins_data_i;
        end else begin
          if (fslot < 0) begin
            fslot = rr;
            if (m[rr].d) begin
              busy = 1'b1; exp_wa = m[rr].t; exp_wd = m[rr].dat;
            end
            rr = (rr + 1) % N;
          end
          m[fslot].v = 1'b1; m[fslot].d = ins_dirty_i;
          m[fslot].t = ins_addr_i; m[fslot].dat = ins_data_i;
        end
      end
      tick();
      pend_look = lookup_req_i;
      exp_hit = n_hit; exp_idx = n_idx; exp_data = n_data; exp_dirty = n_dirty;
    end
    lookup_req_i = 1'b0; take_i = 1'b0; ins_valid_i = 1'b0; wb_ready_i = 1'b0;
    tick();
`ifdef VICTIM_PERF_CNT_EN
    exp_hc = 32'(mh); exp_mc = 32'(mm);
`else
    exp_hc = 32'd0; exp_mc = 32'd0;
`endif
    chk("r_hit_cnt", hit_cnt_o, exp_hc);
    chk("r_miss_cnt", miss_cnt_o, exp_mc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
